// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared definitions for the RGB fade sequencer.
// Holds the state encoding, colour table size and colour lookup.
package rgb_fade_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD,
    S_RAMP_DOWN,
    S_NEXT
  } state_t;

  localparam int         NUM_COLOURS = 7;
  localparam logic [2:0] IDX_LAST    = 3'(NUM_COLOURS - 1);
  localparam logic [2:0] MASK_RESET  = 3'b100;

  // {r,g,b} enable mask for each colour index.
  function automatic logic [2:0] colour_mask(
    input logic [2:0] idx
  );
    logic [2:0] m;
    m = MASK_RESET;
    unique case (idx)
      3'd0:    m = 3'b100;
      3'd1:    m = 3'b010;
      3'd2:    m = 3'b001;
      3'd3:    m = 3'b110;
      3'd4:    m = 3'b011;
      3'd5:    m = 3'b101;
      3'd6:    m = 3'b111;
      default: m = MASK_RESET;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_tick_prescaler.sv
// Brightness-step prescaler: o_tick pulses once every DIV clocks.
// Ports: i_clk, i_reset (async, high), i_run (count enable; 0 holds
// the count at 0), o_tick (high on the cycle count == DIV-1).
module tick_prescaler #(
  parameter int DIV = 300000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-fade sequencer driving the duty inputs of three PWM channels.
// Each colour ramps 0->MAX, holds, ramps MAX->0, then the table advances.
// Ports: i_clk, i_reset (async, high), i_enable (run/fade-out level),
// o_duty_r/g/b (PWM duty), o_mask ({r,g,b} active colour),
// o_busy (state != IDLE), o_wrap (pulse on colour index 6->0).
// Build option: define RGB_FADE_GAMMA_EN for a squared brightness curve
// (duty = level*level >> PWM_BITS, one extra cycle of latency).
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 300000,
  parameter int HOLD_STEPS = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  output logic [PWM_BITS-1:0] o_duty_r,
  output logic [PWM_BITS-1:0] o_duty_g,
  output logic [PWM_BITS-1:0] o_duty_b,
  output logic [2:0]          o_mask,
  output logic                o_busy,
  output logic                o_wrap
);

  localparam int HW = $clog2(HOLD_STEPS + 1);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LVL_PRE =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  state_t              r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [2:0]          r_idx;
  logic [HW-1:0]       r_hold;
  logic [2:0]          r_mask;
  logic                r_busy;
  logic                r_wrap;
  logic [PWM_BITS-1:0] r_duty_r;
  logic [PWM_BITS-1:0] r_duty_g;
  logic [PWM_BITS-1:0] r_duty_b;

  logic                w_run;
  logic                w_tick;
  logic [2:0]          w_idx_nxt;
  logic [PWM_BITS-1:0] w_bright;

  assign w_run = (r_state == S_RAMP_UP)
              || (r_state == S_HOLD)
              || (r_state == S_RAMP_DOWN);

  assign w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_presc (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_idx   <= 3'd0;
      r_hold  <= '0;
      r_mask  <= MASK_RESET;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_level <= '0;
          if (i_enable) begin
            r_state <= S_RAMP_UP;
            r_busy  <= 1'b1;
          end
        end
        S_RAMP_UP: begin
          if (w_tick && r_level != LVL_MAX)
            r_level <= r_level + 1'b1;
          // Disable wins over reaching the top; the tick still lands.
          if (!i_enable) begin
            r_state <= S_RAMP_DOWN;
          end else if (w_tick && r_level == LVL_PRE) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
          end
        end
        S_HOLD: begin
          if (w_tick)
            r_hold <= r_hold + 1'b1;
          if (!i_enable)
            r_state <= S_RAMP_DOWN;
          else if (w_tick && r_hold == HOLD_LAST)
            r_state <= S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          // Level 0 here means enable dropped before the first step.
          if (r_level == '0) begin
            r_state <= S_NEXT;
          end else if (w_tick) begin
            r_level <= r_level - 1'b1;
            if (r_level == LVL_ONE)
              r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_idx   <= w_idx_nxt;
          r_mask  <= colour_mask(w_idx_nxt);
          r_wrap  <= (r_idx == IDX_LAST);
          r_busy  <= i_enable;
          r_state <= i_enable ? S_RAMP_UP : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  logic [PWM_BITS-1:0] w_sq_hi;
  logic [PWM_BITS-1:0] w_sq_lo_unused;
  logic [PWM_BITS-1:0] r_gamma;

  assign {w_sq_hi, w_sq_lo_unused} =
    {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_gamma <= '0;
    else
      r_gamma <= w_sq_hi;
  end

  assign w_bright = r_gamma;
`else
  assign w_bright = r_level;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_duty_r <= '0;
      r_duty_g <= '0;
      r_duty_b <= '0;
    end else begin
      r_duty_r <= r_mask[2] ? w_bright : '0;
      r_duty_g <= r_mask[1] ? w_bright : '0;
      r_duty_b <= r_mask[0] ? w_bright : '0;
    end
  end

  assign o_duty_r = r_duty_r;
  assign o_duty_g = r_duty_g;
  assign o_duty_b = r_duty_b;
  assign o_mask   = r_mask;
  assign o_busy   = r_busy;
  assign o_wrap   = r_wrap;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer (PWM_BITS=4, TICK_DIV=4,
// HOLD_STEPS=2): expected output changes are queued with their cycle.
module tb_rgb_fade_sequencer;

`ifdef RGB_FADE_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          t;
    logic [16:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] duty_r;
  logic [3:0] duty_g;
  logic [3:0] duty_b;
  logic [2:0] mask;
  logic       busy;
  logic       wrap;
  logic [16:0] w_cur;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [16:0] last_v;
  logic [16:0] prev = '0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [2:0] tab [7] = '{3'b100, 3'b010, 3'b001, 3'b110,
                          3'b011, 3'b101, 3'b111};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign w_cur = {duty_r, duty_g, duty_b, mask, busy, wrap};

  rgb_fade_sequencer #(
    .PWM_BITS  (4),
    .TICK_DIV  (4),
    .HOLD_STEPS(2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_enable(en),
    .o_duty_r(duty_r),
    .o_duty_g(duty_g),
    .o_duty_b(duty_b),
    .o_mask  (mask),
    .o_busy  (busy),
    .o_wrap  (wrap)
  );

  function automatic int fl(int l);
`ifdef RGB_FADE_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  function automatic logic [16:0] tup(int f, logic [2:0] m,
                                      logic b, logic w);
    logic [3:0] d;
    d = 4'(f);
    return {m[2] ? d : 4'h0, m[1] ? d : 4'h0,
            m[0] ? d : 4'h0, m, b, w};
  endfunction

  task automatic push(int t, logic [16:0] v);
    ev_t e;
    if (v !== last_v) begin
      e.t = t;
      e.v = v;
      exp_q.push_back(e);
      last_v = v;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One colour: ramp from start s, ramp down from dbase, end at dbase+57.
  task automatic colour(int s, logic [2:0] m, logic [2:0] mn,
                        int dbase, logic b_end, logic w);
    for (int k = 1; k <= 15; k++)
      push(s + 4 * k + LAT, tup(fl(k), m, 1'b1, 1'b0));
    for (int k = 14; k >= 1; k--)
      push(dbase + 4 * (14 - k) + LAT, tup(fl(k), m, 1'b1, 1'b0));
    push(dbase + 57, tup(0, mn, b_end, w));
    if (w) push(dbase + 58, tup(0, mn, b_end, 1'b0));
  endtask

  always @(negedge clk) begin
    if (mon_en && w_cur !== prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: got t=%0d v=%h want none",
                 cyc, w_cur);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.t != cyc || mon_e.v !== w_cur) begin
          n_bad++;
          $display("FAIL out_event: got t=%0d v=%h want t=%0d v=%h",
                   cyc, w_cur, mon_e.t, mon_e.v);
        end
      end
    end
    prev = w_cur;
  end

  initial begin
    int s;
    int c;
    rst = 1'b1;
    en  = 1'b0;
    last_v = tup(0, 3'b100, 1'b0, 1'b0);
    #1 chk("reset_state", 32'(w_cur), 32'(tup(0, 3'b100, 0, 0)));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    wait_cyc(cyc + 10);
    chk("idle_no_enable", 32'(w_cur), 32'(tup(0, 3'b100, 0, 0)));

    // Seven full colours, then colour 8 disabled during HOLD.
    c = cyc;
    s = c + 1;
    push(s, tup(0, 3'b100, 1'b1, 1'b0));
    for (int i = 0; i < 7; i++) begin
      colour(s, tab[i], tab[(i + 1) % 7], s + 72, 1'b1, i == 6);
      s += 129;
    end
    colour(s, 3'b100, 3'b010, s + 64, 1'b0, 1'b0);
    en = 1'b1;
    wait_cyc(s + 61);
    en = 1'b0;
    wait_cyc(s + 125);
    chk("full_run_drained", 32'(exp_q.size()), 32'd0);

    // Two-clock enable pulse: no brightness, index advances.
    c = cyc;
    push(c + 1, tup(0, 3'b010, 1'b1, 1'b0));
    push(c + 5, tup(0, 3'b001, 1'b0, 1'b0));
    en = 1'b1;
    wait_cyc(c + 2);
    en = 1'b0;
    wait_cyc(c + 8);
    chk("pulse_drained", 32'(exp_q.size()), 32'd0);

    // Enable falls on a tick cycle in RAMP_UP.
    c = cyc;
    push(c + 1, tup(0, 3'b001, 1'b1, 1'b0));
    push(c + 5 + LAT, tup(fl(1), 3'b001, 1'b1, 1'b0));
    push(c + 9 + LAT, tup(fl(2), 3'b001, 1'b1, 1'b0));
    push(c + 13 + LAT, tup(fl(1), 3'b001, 1'b1, 1'b0));
    push(c + 18, tup(0, 3'b110, 1'b0, 1'b0));
    en = 1'b1;
    wait_cyc(c + 8);
    en = 1'b0;
    wait_cyc(c + 22);
    chk("tick_fall_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a ramp.
    c = cyc;
    push(c + 1, tup(0, 3'b110, 1'b1, 1'b0));
    for (int k = 1; k <= 3; k++)
      push(c + 1 + 4 * k + LAT, tup(fl(k), 3'b110, 1'b1, 1'b0));
    en = 1'b1;
    wait_cyc(c + 15);
    #2;
    chk("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1 chk("mid_reset", 32'(w_cur), 32'(tup(0, 3'b100, 0, 0)));
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(cyc + 6);
    chk("idle_after_reset", 32'(w_cur), 32'(tup(0, 3'b100, 0, 0)));
    last_v = tup(0, 3'b100, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Restart begins again at the red entry.
    c = cyc;
    push(c + 1, tup(0, 3'b100, 1'b1, 1'b0));
    for (int k = 1; k <= 5; k++)
      push(c + 1 + 4 * k + LAT, tup(fl(k), 3'b100, 1'b1, 1'b0));
    en = 1'b1;
    wait_cyc(c + 24);
    #1 chk("restart_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
